// File: rtl/kianv_mem_arbiter_if.sv
// rtl/kianv_mem_arbiter_if.sv - bus bundle between upstream masters, the arbiter and the memory port
// slave modport is the arbiter's view; master modport is the masters/memory side.
interface kianv_mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int GRANT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            s_valid;
  logic [NUM_PORTS-1:0]            s_ready;
  logic [NUM_PORTS-1:0]            s_lock;
  logic [NUM_PORTS*STRB_WIDTH-1:0] s_wstrb;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_wdata;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_rdata;
  logic [NUM_PORTS-1:0]            s_access_fault;

  logic                            mem_valid;
  logic                            mem_ready;
  logic [STRB_WIDTH-1:0]           mem_wstrb;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            access_fault;

  logic [GRANT_WIDTH-1:0]          grant_id;
  logic                            snoop_valid;
  logic [ADDR_WIDTH-1:0]           snoop_addr;
  logic [GRANT_WIDTH-1:0]          snoop_src;

  modport slave (
    input  s_valid, s_lock, s_wstrb, s_addr, s_wdata, mem_ready, mem_rdata, access_fault,
    output s_ready, s_rdata, s_access_fault, mem_valid, mem_wstrb, mem_addr, mem_wdata,
           grant_id, snoop_valid, snoop_addr, snoop_src
  );

  modport master (
    output s_valid, s_lock, s_wstrb, s_addr, s_wdata, mem_ready, mem_rdata, access_fault,
    input  s_ready, s_rdata, s_access_fault, mem_valid, mem_wstrb, mem_addr, mem_wdata,
           grant_id, snoop_valid, snoop_addr, snoop_src
  );
endinterface

// File: rtl/kianv_mem_arbiter.sv
// rtl/kianv_mem_arbiter.sv - N-port round-robin memory arbiter with per-port bus lock
// Optional write-snoop broadcast is enabled by defining KIANV_ARB_SNOOP_EN.
module kianv_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  kianv_mem_arbiter_if.slave  bus
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IW = GW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   w_grant_next;
  logic [GW-1:0]   r_rr_last;
  logic [GW-1:0]   w_rr_last_next;
  logic [GW-1:0]   w_rr_pick;
  logic [IW-1:0]   w_sum;
  logic            w_any_req;
  logic            w_done;

  // Scan from farthest to nearest so the nearest requester after rr_last wins.
  always_comb begin
    w_rr_pick = r_rr_last;
    w_any_req = 1'b0;
    w_sum     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      w_sum = {1'b0, r_rr_last} + IW'(i);
      if (w_sum >= IW'(NUM_PORTS)) begin
        w_sum = w_sum - IW'(NUM_PORTS);
      end
      if (bus.s_valid[w_sum[GW-1:0]]) begin
        w_rr_pick = w_sum[GW-1:0];
        w_any_req = 1'b1;
      end
    end
  end

  assign w_done = (r_state == S_BUSY) && bus.mem_ready;

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_rr_last_next = r_rr_last;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_next = w_rr_pick;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_ready) begin
          w_rr_last_next = r_grant;
          w_state_next   = bus.s_lock[r_grant] ? S_LOCKED : S_IDLE;
        end
      end
      S_LOCKED: begin
        if (bus.s_valid[r_grant]) begin
          w_state_next = S_BUSY;
        end else if (!bus.s_lock[r_grant]) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_last <= GW'(NUM_PORTS - 1);
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_rr_last <= w_rr_last_next;
    end
  end

  assign bus.mem_valid      = (r_state == S_BUSY);
  assign bus.mem_addr       = bus.s_addr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_wstrb      = bus.s_wstrb[r_grant*(DATA_WIDTH/8) +: (DATA_WIDTH/8)];
  assign bus.mem_wdata      = bus.s_wdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id       = r_grant;
  assign bus.s_ready        = w_done ? (NUM_PORTS'(1) << r_grant) : '0;
  assign bus.s_access_fault = (w_done && bus.access_fault) ? (NUM_PORTS'(1) << r_grant) : '0;
  assign bus.s_rdata        = {NUM_PORTS{bus.mem_rdata}};

`ifdef KIANV_ARB_SNOOP_EN
  logic                  r_snoop_valid;
  logic [ADDR_WIDTH-1:0] r_snoop_addr;
  logic [GW-1:0]         r_snoop_src;
  logic                  w_write_done;

  assign w_write_done = w_done && (|bus.mem_wstrb);

  // Word-aligned address so other harts can compare against their LR reservation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snoop_valid <= 1'b0;
      r_snoop_addr  <= '0;
      r_snoop_src   <= '0;
    end else begin
      r_snoop_valid <= w_write_done;
      if (w_write_done) begin
        r_snoop_addr <= {bus.mem_addr[ADDR_WIDTH-1:2], 2'b00};
        r_snoop_src  <= r_grant;
      end
    end
  end

  assign bus.snoop_valid = r_snoop_valid;
  assign bus.snoop_addr  = r_snoop_addr;
  assign bus.snoop_src   = r_snoop_src;
`else
  assign bus.snoop_valid = 1'b0;
  assign bus.snoop_addr  = '0;
  assign bus.snoop_src   = '0;
`endif

  // A granted master must keep s_valid up until its s_ready.
  property p_hold_valid;
    @(posedge clk) disable iff (reset) (r_state == S_BUSY) |-> bus.s_valid[r_grant];
  endproperty
  a_hold_valid: assert property (p_hold_valid);

endmodule

// File: tb/tb_kianv_mem_arbiter.sv
// tb/tb_kianv_mem_arbiter.sv - self-checking bench for kianv_mem_arbiter (3 ports)
// Snoop expectations follow KIANV_ARB_SNOOP_EN.
module tb_kianv_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int GW = 2;
`ifdef KIANV_ARB_SNOOP_EN
  localparam bit SNOOP_EN = 1'b1;
`else
  localparam bit SNOOP_EN = 1'b0;
`endif

  typedef struct {
    int            port;
    logic [SW-1:0] wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          fault;
    int            lat;
    logic [AW-1:0] exp_snoop_addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  kianv_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  kianv_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic lk, input logic [SW-1:0] ws,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.s_valid[p]            = v;
    bus.s_lock[p]             = lk;
    bus.s_wstrb[p*SW +: SW]   = ws;
    bus.s_addr[p*AW +: AW]    = a;
    bus.s_wdata[p*DW +: DW]   = d;
  endtask

  task automatic idle_inputs;
    bus.s_valid      = '0;
    bus.s_lock       = '0;
    bus.s_wstrb      = '0;
    bus.s_addr       = '0;
    bus.s_wdata      = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;
    bus.access_fault = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  function automatic int rr_pick(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (req[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [NP-1:0] one;
    logic          is_wr;
    one   = NP'(1) << v.port;
    is_wr = (v.wstrb != 0);
    cyc();
    set_port(v.port, 1'b1, 1'b0, v.wstrb, v.addr, v.wdata);
    #1;
    check("vec_idle_mem_valid", bus.mem_valid, 0);
    for (int k = 0; k <= v.lat; k++) begin
      cyc();
      bus.mem_ready    = (k == v.lat);
      bus.mem_rdata    = v.rdata;
      bus.access_fault = (k == v.lat) ? v.fault : 1'b0;
      #1;
      if (k == 0) begin
        check("vec_mem_valid", bus.mem_valid, 1);
        check("vec_grant", bus.grant_id, v.port);
        check("vec_mem_addr", bus.mem_addr, v.addr);
        check("vec_mem_wstrb", bus.mem_wstrb, v.wstrb);
        check("vec_mem_wdata", bus.mem_wdata, v.wdata);
      end
      if (k < v.lat) begin
        check("vec_wait_s_ready", bus.s_ready, 0);
        check("vec_wait_mem_valid", bus.mem_valid, 1);
      end else begin
        check("vec_s_ready", bus.s_ready, one);
        check("vec_s_rdata", bus.s_rdata[v.port*DW +: DW], v.rdata);
        check("vec_s_fault", bus.s_access_fault, v.fault ? one : '0);
      end
    end
    cyc();
    set_port(v.port, 1'b0, 1'b0, '0, '0, '0);
    bus.mem_ready    = 1'b0;
    bus.access_fault = 1'b0;
    #1;
    check("vec_gap_mem_valid", bus.mem_valid, 0);
    check("vec_snoop_valid", bus.snoop_valid, SNOOP_EN && is_wr);
    if (is_wr) begin
      check("vec_snoop_addr", bus.snoop_addr, SNOOP_EN ? v.exp_snoop_addr : '0);
      check("vec_snoop_src", bus.snoop_src, SNOOP_EN ? v.port : 0);
    end
    cyc();
    check("vec_snoop_pulse_end", bus.snoop_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[5];
    int            n;
    logic          prev_mv;
    logic [NP-1:0] out;
    logic [AW-1:0] q_addr[NP];
    logic [SW-1:0] q_wstrb[NP];
    logic [DW-1:0] q_wdata[NP];
    int            wait_cnt[NP];
    logic [NP-1:0] sv_prev;
    logic          mv;
    logic          prev_ready;
    int            prev_port;
    int            cur;
    int            g;
    int            last;
    int            lat_left;
    logic [DW-1:0] rd;
    logic          flt;

    vecs[0] = '{0, 4'h0, 34'h0_8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 34'h0};
    vecs[1] = '{1, 4'hF, 34'h3_0000_0000, 32'h1234_5678, 32'h0,         1'b1, 1, 34'h3_0000_0000};
    vecs[2] = '{0, 4'h3, 34'h0_8000_0022, 32'h0000_A5A5, 32'h0,         1'b0, 2, 34'h0_8000_0020};
    vecs[3] = '{2, 4'h0, 34'h1_2345_6788, 32'h0,         32'h0BAD_F00D, 1'b0, 0, 34'h0};
    vecs[4] = '{2, 4'h8, 34'h2_FFFF_FFFF, 32'hCAFE_0000, 32'h0,         1'b0, 1, 34'h2_FFFF_FFFC};

    do_reset();
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_s_fault", bus.s_access_fault, 0);
    check("rst_grant", bus.grant_id, 0);
    check("rst_snoop_valid", bus.snoop_valid, 0);
    check("rst_snoop_addr", bus.snoop_addr, 0);
    check("rst_snoop_src", bus.snoop_src, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // all ports continuously requesting, memory always ready
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, '0, AW'(34'h100 + p * 4), '0);
    n = 0;
    prev_mv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      bus.mem_ready = bus.mem_valid;
      #1;
      check("rr_alternate", bus.mem_valid, !prev_mv);
      if (bus.mem_valid) begin
        check("rr_grant", bus.grant_id, n % NP);
        check("rr_mem_addr", bus.mem_addr, AW'(34'h100 + (n % NP) * 4));
        n++;
      end
      prev_mv = bus.mem_valid;
    end
    check("rr_count", n, 6);

    // lock: port1 read then write with lock held, port0 waiting
    do_reset();
    set_port(1, 1'b1, 1'b1, 4'h0, 34'h1000, 32'h0);
    cyc();
    set_port(0, 1'b1, 1'b0, 4'h0, 34'h2000, 32'h0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    #1;
    check("lock_rd_grant", bus.grant_id, 1);
    check("lock_rd_ready", bus.s_ready, 3'b010);
    check("lock_rd_addr", bus.mem_addr, 34'h1000);
    cyc();
    bus.mem_ready = 1'b0;
    set_port(1, 1'b0, 1'b1, 4'h0, 34'h1000, 32'h0);
    #1;
    check("lock_hold_mv", bus.mem_valid, 0);
    cyc();
    set_port(1, 1'b1, 1'b1, 4'hF, 34'h1000, 32'h5);
    #1;
    check("lock_blocks_port0", bus.mem_valid, 0);
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("lock_wr_grant", bus.grant_id, 1);
    check("lock_wr_wstrb", bus.mem_wstrb, 4'hF);
    check("lock_wr_wdata", bus.mem_wdata, 32'h5);
    check("lock_wr_ready", bus.s_ready, 3'b010);
    cyc();
    bus.mem_ready = 1'b0;
    set_port(1, 1'b0, 1'b1, 4'h0, 34'h1000, 32'h0);
    #1;
    check("lock_after_wr_mv", bus.mem_valid, 0);
    check("lock_snoop_valid", bus.snoop_valid, SNOOP_EN);
    check("lock_snoop_addr", bus.snoop_addr, SNOOP_EN ? 34'h1000 : 34'h0);
    check("lock_snoop_src", bus.snoop_src, SNOOP_EN ? 1 : 0);
    cyc();
    set_port(1, 1'b0, 1'b0, 4'h0, 34'h0, 32'h0);
    #1;
    check("lock_still_held_mv", bus.mem_valid, 0);
    cyc();
    #1;
    check("lock_release_mv", bus.mem_valid, 0);
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("lock_port0_mv", bus.mem_valid, 1);
    check("lock_port0_grant", bus.grant_id, 0);
    check("lock_port0_addr", bus.mem_addr, 34'h2000);
    check("lock_port0_ready", bus.s_ready, 3'b001);
    cyc();
    idle_inputs();
    #1;
    check("lock_end_mv", bus.mem_valid, 0);

    // reset asserted in BUSY; rr_last must return to NUM_PORTS-1
    do_reset();
    set_port(0, 1'b1, 1'b0, 4'h0, 34'h40, 32'h0);
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("rstmid_pre_grant", bus.grant_id, 0);
    cyc();
    bus.mem_ready = 1'b0;
    set_port(0, 1'b0, 1'b0, 4'h0, 34'h0, 32'h0);
    set_port(2, 1'b1, 1'b0, 4'h0, 34'h80, 32'h0);
    cyc();
    #1;
    check("rstmid_busy_grant", bus.grant_id, 2);
    check("rstmid_busy_mv", bus.mem_valid, 1);
    reset = 1'b1;
    cyc();
    #1;
    check("rstmid_mv", bus.mem_valid, 0);
    check("rstmid_s_ready", bus.s_ready, 0);
    check("rstmid_grant", bus.grant_id, 0);
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 4'h0, 34'h44, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 34'h48, 32'h0);
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("rstmid_first_grant", bus.grant_id, 0);
    check("rstmid_first_ready", bus.s_ready, 3'b001);
    cyc();
    do_reset();

    // randomized traffic against a request-queue model
    out        = '0;
    last       = NP - 1;
    prev_mv    = 1'b0;
    prev_ready = 1'b0;
    prev_port  = 0;
    cur        = 0;
    lat_left   = 0;
    for (int p = 0; p < NP; p++) begin
      wait_cnt[p] = 0;
      q_addr[p]   = '0;
      q_wstrb[p]  = '0;
      q_wdata[p]  = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      cyc();
      sv_prev = bus.s_valid;
      mv      = bus.mem_valid;
      if (prev_ready) begin
        out[prev_port] = 1'b0;
        set_port(prev_port, 1'b0, 1'b0, '0, '0, '0);
        check("rand_gap", mv, 0);
      end
      if (!prev_mv) check("rand_arb_latency", mv, |sv_prev);
      if (mv && !prev_mv) begin
        g = rr_pick(sv_prev, last);
        check("rand_grant", bus.grant_id, g);
        if (g < 0) g = 0;
        check("rand_starvation_ok", wait_cnt[g] <= NP - 1, 1);
        wait_cnt[g] = 0;
        for (int p = 0; p < NP; p++) if (p != g && sv_prev[p]) wait_cnt[p]++;
        cur      = g;
        last     = g;
        lat_left = $urandom_range(0, 3);
      end
      if (mv) begin
        check("rand_mem_addr", bus.mem_addr, q_addr[cur]);
        check("rand_mem_wstrb", bus.mem_wstrb, q_wstrb[cur]);
        check("rand_mem_wdata", bus.mem_wdata, q_wdata[cur]);
      end
      for (int p = 0; p < NP; p++) begin
        if (!out[p] && $urandom_range(0, 2) == 0) begin
          q_addr[p]  = {2'($urandom_range(0, 3)), 32'($urandom)};
          q_wstrb[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
          q_wdata[p] = $urandom;
          out[p]     = 1'b1;
          set_port(p, 1'b1, 1'b0, q_wstrb[p], q_addr[p], q_wdata[p]);
        end
      end
      rd  = $urandom;
      flt = ($urandom_range(0, 3) == 0);
      if (mv && lat_left == 0) begin
        bus.mem_ready    = 1'b1;
        bus.mem_rdata    = rd;
        bus.access_fault = flt;
      end else begin
        if (mv) lat_left--;
        bus.mem_ready    = 1'b0;
        bus.access_fault = 1'b0;
      end
      #1;
      if (bus.mem_ready) begin
        check("rand_s_ready", bus.s_ready, NP'(1) << cur);
        check("rand_s_rdata", bus.s_rdata[cur*DW +: DW], rd);
        check("rand_s_fault", bus.s_access_fault, flt ? (NP'(1) << cur) : '0);
      end else begin
        check("rand_s_ready_idle", bus.s_ready, 0);
      end
      prev_ready = bus.mem_ready;
      prev_port  = cur;
      prev_mv    = mv;
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kianv_mem_arbiter.md
Name: kianv_mem_arbiter

Overview:
- Parametrised N-port round-robin arbiter that merges the physical memory buses of several kianv cores (or a core plus DMA/peripheral masters) onto one valid/ready memory port.
- Uses the same bus shape as the core's MMU-side interface: valid, ready, wstrb, 34-bit physical address, wdata, rdata, access_fault.
- A per-port lock input keeps an atomic read-modify-write sequence indivisible.
- Sits between the core instances and the SoC memory/peripheral interconnect in multi-hart builds.

Parameters:
- NUM_PORTS, 2, number of upstream masters (1..8).
- ADDR_WIDTH, 34, physical address width.
- DATA_WIDTH, 32, data width; wstrb width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  NUM_PORTS  per-port request.
- s_ready  out  NUM_PORTS  per-port completion pulse.
- s_lock  in  NUM_PORTS  per-port bus-lock request (AMO sequence).
- s_wstrb  in  NUM_PORTS*DATA_WIDTH/8  per-port byte strobes; all-zero means read.
- s_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address.
- s_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- s_rdata  out  NUM_PORTS*DATA_WIDTH  per-port read data.
- s_access_fault  out  NUM_PORTS  per-port fault, qualified by s_ready.
- mem_valid  out  1  downstream request.
- mem_ready  in  1  downstream completion.
- mem_wstrb  out  DATA_WIDTH/8  downstream strobes.
- mem_addr  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_rdata  in  DATA_WIDTH  downstream read data.
- access_fault  in  1  downstream fault, qualified by mem_ready.
- grant_id  out  clog2(NUM_PORTS) (min 1)  currently owning port.
- snoop_valid  out  1  write-completion broadcast (optional feature).
- snoop_addr  out  ADDR_WIDTH  address of the completed write.
- snoop_src  out  clog2(NUM_PORTS) (min 1)  port that performed the write.

Behaviour:
- Reset values: state IDLE; mem_valid=0; s_ready=0; s_access_fault=0; grant_id=0; rr_last=NUM_PORTS-1; snoop_valid=0; snoop_addr=0; snoop_src=0.
- A reset asserted mid-transaction forces IDLE on the next edge and drops mem_valid. The transaction is abandoned and no s_ready is issued.
- Requester protocol: each master holds s_valid and its payload stable until it sees its s_ready. Deasserting s_valid early is a protocol violation; the implementation must flag it with a simulation assertion.
- State IDLE:
  - If any s_valid is set, select the first requesting port after rr_last, searching cyclically and wrapping from NUM_PORTS-1 to 0.
  - Register that port as grant_id and go to BUSY.
  - Arbitration latency is exactly 1 cycle.
- State BUSY:
  - mem_valid=1. mem_addr, mem_wstrb and mem_wdata are combinational muxes of the granted port's inputs.
  - On mem_ready, in the same cycle:
    - s_ready[grant] is set.
    - s_rdata[grant] = mem_rdata.
    - s_access_fault[grant] = access_fault.
    - rr_last <= grant.
  - Next state: LOCKED if s_lock[grant]=1 in that cycle, otherwise IDLE.
  - mem_valid is low for at least one cycle between transactions.
- State LOCKED:
  - Only the owning port is considered; all other requests wait.
  - If s_valid[grant] is set, go to BUSY with the grant unchanged.
  - Else if s_lock[grant]=0, go to IDLE.
  - Else remain in LOCKED.
- Outputs to non-granted ports: s_ready=0, s_access_fault=0. s_rdata for non-granted ports is don't-care; drive mem_rdata to all ports.
- Single requester: granted every time, with a 2-cycle minimum turnaround (IDLE→BUSY→ready).
- All ports requesting: strict rotation 0,1,…,N-1,0.
- NUM_PORTS=1: arbitration degenerates, but the state machine and 1-cycle latency are unchanged.
- Starvation bound: a waiting port is served within NUM_PORTS-1 other unlocked transactions.

Optional Feature:
- Macro: KIANV_ARB_SNOOP_EN.
- Defined: one cycle after any completed write (mem_ready in BUSY with mem_wstrb≠0):
  - snoop_valid pulses high for exactly 1 cycle.
  - snoop_addr = registered mem_addr with bits [1:0] cleared.
  - snoop_src = grant.
  - Cores use this to clear LR reservations on other harts.
  - Reads never snoop.
- Undefined: snoop_valid, snoop_addr and snoop_src are constant 0, and no snoop registers are synthesised.

Test Plan:
- Single read: port0 read, addr 0x0_8000_0010; mem_ready after 3 cycles with rdata 0xDEADBEEF → mem_valid rises 1 cycle after s_valid; s_ready[0] pulses in the mem_ready cycle with s_rdata[0]=0xDEADBEEF.
- Round-robin: NUM_PORTS=3, all ports issue continuous reads, mem_ready=1 always → grant sequence 0,1,2,0,1,2; mem_valid low for 1 cycle between transactions.
- Lock: port1 reads 0x1000 with s_lock=1, then writes 0x1000 (wstrb=0xF, wdata=5) while port0 is requesting → port0 is granted only after the port1 write completes and s_lock drops.
- Fault: port1 write to 0x3_0000_0000; access_fault=1 with mem_ready → s_access_fault[1]=1 for 1 cycle; s_access_fault[0]=0.
- Reset mid-operation: reset asserted while in BUSY before mem_ready → next cycle mem_valid=0, s_ready=0, grant_id=0; the first request after reset goes to port0.
- Snoop (KIANV_ARB_SNOOP_EN defined): port0 writes 0x0_8000_0022 → the cycle after completion, snoop_valid=1, snoop_addr=0x0_8000_0020, snoop_src=0; a read produces no pulse.
